// File: rtl/order_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// order_dispatch_pkg
//
// Shared definitions for the order dispatcher:
//   - order code constants (END marker, reserved code)
//   - field widths for order code, order id and completion counter
//   - dispatcher FSM state encoding
//   - helper that classifies an order code as a valid engine select
//
// Optional feature macro used by the design: ORDER_TIMEOUT_EN
// -----------------------------------------------------------------------------
package order_dispatch_pkg;

   localparam int CODE_W = 3;
   localparam int ID_W   = 32;
   localparam int CNT_W  = 16;

   localparam logic [CODE_W-1:0] ORD_RSVD = 3'd0;
   localparam logic [CODE_W-1:0] ORD_END  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAT       = 3'd1,
      S_DECODE    = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_COMPLETE  = 3'd5
   } state_t;

   // True when the code selects one of the first num_engines engines.
   // Code 0 is reserved and code 7 is the END marker, so neither ever
   // selects an engine regardless of how many engines are built.
   function automatic logic code_is_engine(input logic [CODE_W-1:0] code,
                                           input int                num_engines);
      return (code != ORD_RSVD) && (code != ORD_END) &&
             (int'(code) <= num_engines);
   endfunction

endpackage : order_dispatch_pkg

// File: rtl/order_dispatch_watchdog.sv
// -----------------------------------------------------------------------------
// order_watchdog
//
// Cycle counter used to bound the wait for an engine done pulse.
// The counter is held at zero while clear is high and counts up while run is
// high. expired is asserted combinationally on the LIMIT-th consecutive run
// cycle, so the owner can act on it in that same cycle.
//
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  hold the counter at zero
//   run      in  count this cycle
//   expired  out LIMIT run cycles have elapsed since the last clear
//
// Built only when ORDER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module order_watchdog #(
   parameter int LIMIT = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int          W    = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

   // count reads LAST during the LIMIT-th run cycle after a clear.
   assign expired = run && (count == LAST);

endmodule : order_watchdog

// File: rtl/order_dispatch.sv
// -----------------------------------------------------------------------------
// order_dispatch
//
// Order sequencer sitting downstream of the order cache FIFO. Pops one order,
// lets the cache register the order fields, decodes the code, pulses the start
// line of the selected engine and waits for that engine's done pulse before
// publishing completion status.
//
// Ports:
//   system_clk    in   clock
//   rst_n         in   asynchronous active-low reset
//   run_en        in   dispatch permitted while high
//   status_clear  in   pulse; clears halted, order_err, timeout_err
//   pop_order_en  out  pop request to the cache (combinational)
//   order_valid   in   pop accepted this cycle
//   order         in   order code from the cache
//   id            in   order id from the cache
//   engine_start  out  one-hot start pulse, bit = order-1
//   engine_done   in   done pulses from the engines
//   engine_abort  out  pulse on watchdog expiry
//   busy          out  high in every state except IDLE (combinational)
//   halted        out  sticky, set by END
//   end_irq       out  pulse when END is decoded
//   complete      out  pulse per finished engine order
//   last_id       out  id of the latest completed or END order
//   done_count    out  completed engine orders, wraps
//   order_err     out  sticky, set on an invalid order code
//   timeout_err   out  sticky watchdog flag
//   fsm_state     out  current FSM state for observation
//
// Handshake: the cache accepts a pop in any cycle where pop_order_en and
// order_valid are both high; the order fields are then stable from the
// DECODE cycle onwards. engine_start and engine_done are single-cycle pulses
// with no back-pressure.
//
// Optional feature macro: ORDER_TIMEOUT_EN (watchdog on the done wait).
// -----------------------------------------------------------------------------
module order_dispatch
   import order_dispatch_pkg::*;
#(
   parameter int NUM_ENGINES    = 6,
   parameter int TIMEOUT_CYCLES = (1 << 24) - 1
) (
   input  logic                   system_clk,
   input  logic                   rst_n,
   input  logic                   run_en,
   input  logic                   status_clear,
   output logic                   pop_order_en,
   input  logic                   order_valid,
   input  logic [CODE_W-1:0]      order,
   input  logic [ID_W-1:0]        id,
   output logic [NUM_ENGINES-1:0] engine_start,
   input  logic [NUM_ENGINES-1:0] engine_done,
   output logic                   engine_abort,
   output logic                   busy,
   output logic                   halted,
   output logic                   end_irq,
   output logic                   complete,
   output logic [ID_W-1:0]        last_id,
   output logic [CNT_W-1:0]       done_count,
   output logic                   order_err,
   output logic                   timeout_err,
   output state_t                 fsm_state
);

   state_t                 state;
   logic [CODE_W-1:0]      code_q;
   logic [ID_W-1:0]        id_q;
   logic [NUM_ENGINES-1:0] start_sel;
   logic [NUM_ENGINES-1:0] wait_sel;
   logic                   done_hit;
   logic                   wd_expired;

   // One-hot engine selects: start_sel from the live code during DECODE,
   // wait_sel from the captured code while waiting for done.
   always_comb begin
      start_sel = '0;
      wait_sel  = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         start_sel[i] = (int'(order)  == i + 1);
         wait_sel[i]  = (int'(code_q) == i + 1);
      end
   end

   // Done pulses from engines other than the selected one are ignored.
   assign done_hit = |(engine_done & wait_sel);

   assign pop_order_en = (state == S_IDLE) && run_en && !halted;
   assign busy         = (state != S_IDLE);
   assign fsm_state    = state;

`ifdef ORDER_TIMEOUT_EN
   logic abort_q;
   logic timeout_q;

   // Held clear outside WAIT_DONE, so every entry starts from zero.
   order_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_order_watchdog (
      .clk     (system_clk),
      .rst_n   (rst_n),
      .clear   (state != S_WAIT_DONE),
      .run     (state == S_WAIT_DONE),
      .expired (wd_expired)
   );

   assign engine_abort = abort_q;
   assign timeout_err  = timeout_q;
`else
   assign wd_expired   = 1'b0;
   assign engine_abort = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         code_q       <= '0;
         id_q         <= '0;
         engine_start <= '0;
         halted       <= 1'b0;
         end_irq      <= 1'b0;
         complete     <= 1'b0;
         last_id      <= '0;
         done_count   <= '0;
         order_err    <= 1'b0;
`ifdef ORDER_TIMEOUT_EN
         abort_q      <= 1'b0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low; they are raised on the transition
         // into the state in which they must be visible.
         engine_start <= '0;
         end_irq      <= 1'b0;
         complete     <= 1'b0;
`ifdef ORDER_TIMEOUT_EN
         abort_q      <= 1'b0;
`endif

         // Clear first so that a set in the same cycle below takes priority.
         if (status_clear) begin
            halted    <= 1'b0;
            order_err <= 1'b0;
`ifdef ORDER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
         end

         case (state)
            S_IDLE: begin
               if (pop_order_en && order_valid) begin
                  state <= S_LAT;
               end
            end

            // The cache registers the popped fields at the end of this cycle.
            S_LAT: begin
               state <= S_DECODE;
            end

            S_DECODE: begin
               code_q <= order;
               id_q   <= id;
               if (order == ORD_END) begin
                  halted  <= 1'b1;
                  end_irq <= 1'b1;
                  last_id <= id;
                  state   <= S_IDLE;
               end else if (code_is_engine(order, NUM_ENGINES)) begin
                  engine_start <= start_sel;
                  state        <= S_ISSUE;
               end else begin
                  // Invalid code: the order is dropped.
                  order_err <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            // engine_start is high during this cycle.
            S_ISSUE: begin
               state <= S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
               if (done_hit) begin
                  complete   <= 1'b1;
                  last_id    <= id_q;
                  done_count <= done_count + 1'b1;
                  state      <= S_COMPLETE;
`ifdef ORDER_TIMEOUT_EN
               end else if (wd_expired) begin
                  abort_q   <= 1'b1;
                  timeout_q <= 1'b1;
                  state     <= S_IDLE;
`endif
               end
            end

            // complete is high during this cycle; status is already updated.
            S_COMPLETE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule : order_dispatch
